// File: rtl/combination.sv
// combination: streaming (PATTERN){1,MAX_REP} run detector, one char per txn.
// Macro COMBINATION_LAST_CHAR_EN: a last=1 txn also consumes char first.
module combination #(
  parameter int                   PAT_LEN  = 2,
  parameter logic [8*PAT_LEN-1:0] PATTERN  = 16'h6162,
  parameter int                   MAX_REP  = 4,
  parameter int                   RST_FULL = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rdy,
  input  logic [7:0]  char,
  input  logic        last,
  output logic        match,
  output logic [31:0] startPos,
  output logic [31:0] endPos
);

  localparam int OW = $clog2(PAT_LEN + 1);
  localparam int RW = $clog2(MAX_REP + 1);
  localparam int CW = $clog2(RST_FULL + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OW-1:0] PL   = OW'(PAT_LEN);
  localparam logic [RW-1:0] MR   = RW'(MAX_REP);
  localparam logic [CW-1:0] RF   = CW'(RST_FULL);
  localparam logic [31:0]   PL32 = 32'(PAT_LEN);

  // FSM and transaction latch
  logic [1:0]    state_q, state_d;
  logic [7:0]    c_q, c_d;
  logic          last_q, last_d;

  // registered outputs
  logic          rdy_q, rdy_d;
  logic          match_q, match_d;
  logic [31:0]   sp_q, sp_d;
  logic [31:0]   ep_q, ep_d;

  // stream context, survives short resets
  logic [31:0]   pos_q, pos_d;
  logic [31:0]   rs_q, rs_d;
  logic [OW-1:0] off_q, off_d;
  logic [RW-1:0] rep_q, rep_d;

  // consecutive reset-high cycle counter
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          full_clr;

  // evaluation results
  logic          do_data;
  logic          hit;
  logic [31:0]   hit_sp;
  logic [31:0]   hit_ep;
  logic [31:0]   n_pos;
  logic [31:0]   n_rs;
  logic [OW-1:0] n_off;
  logic [RW-1:0] n_rep;

  // pattern bytes, padded to a power of two so off_q indexes exactly
  logic [7:0] pat_b [2**OW];

  for (genvar i = 0; i < 2**OW; i++) begin : g_pat
    if (i < PAT_LEN) begin : g_used
      assign pat_b[i] = PATTERN[8*(PAT_LEN-1-i) +: 8];
    end else begin : g_pad
      assign pat_b[i] = 8'h00;
    end
  end

  // saturating count of reset-high cycles; reaching RF wipes context
  always_comb begin
    cnt_inc  = (cnt_q >= RF) ? RF : cnt_q + 1'b1;
    full_clr = (cnt_inc >= RF);
  end

  // one character step plus optional end-of-stream flush
  always_comb begin
    n_pos   = pos_q;
    n_rs    = rs_q;
    n_off   = off_q;
    n_rep   = rep_q;
    hit     = 1'b0;
    hit_sp  = '0;
    hit_ep  = '0;
`ifdef COMBINATION_LAST_CHAR_EN
    do_data = 1'b1;
`else
    do_data = !last_q;
`endif
    if (do_data) begin
      if (c_q == pat_b[off_q]) begin
        if (off_q == PL - 1'b1) begin
          n_off = '0;
          if (rep_q == '0) begin
            n_rs = pos_q - PL32 + 32'd1;
          end
          n_rep = rep_q + 1'b1;
          if (n_rep == MR) begin
            hit    = 1'b1;
            hit_sp = n_rs;
            hit_ep = pos_q;
            n_rep  = '0;
          end
        end else begin
          n_off = off_q + 1'b1;
        end
      end else begin
        // partial repetition is dropped: run ends before it
        if (rep_q != '0) begin
          hit    = 1'b1;
          hit_sp = rs_q;
          hit_ep = pos_q - 32'(off_q) - 32'd1;
        end
        n_rep = '0;
        n_off = (c_q == pat_b[0]) ? OW'(1) : '0;
      end
      n_pos = pos_q + 32'd1;
    end
    if (last_q) begin
      // at most one report; a data-step report wins over the flush
      if (!hit && n_rep != '0) begin
        hit    = 1'b1;
        hit_sp = n_rs;
        hit_ep = n_pos - 32'(n_off) - 32'd1;
      end
      n_pos = '0;
      n_rs  = '0;
      n_off = '0;
      n_rep = '0;
    end
  end

  // FSM next state: latch in IDLE, commit in EVAL, hold in DONE
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    last_d  = last_q;
    rdy_d   = rdy_q;
    match_d = match_q;
    sp_d    = sp_q;
    ep_d    = ep_q;
    pos_d   = pos_q;
    rs_d    = rs_q;
    off_d   = off_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE: begin
        c_d     = char;
        last_d  = last;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        pos_d   = n_pos;
        rs_d    = n_rs;
        off_d   = n_off;
        rep_d   = n_rep;
        rdy_d   = 1'b1;
        match_d = hit;
        sp_d    = hit_sp;
        ep_d    = hit_ep;
        state_d = S_DONE;
      end
      default: begin
      end
    endcase
  end

  // state update; reset aborts the txn, long reset also clears context
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      match_q <= 1'b0;
      sp_q    <= '0;
      ep_q    <= '0;
      cnt_q   <= cnt_inc;
      if (full_clr) begin
        pos_q <= '0;
        rs_q  <= '0;
        off_q <= '0;
        rep_q <= '0;
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      match_q <= match_d;
      sp_q    <= sp_d;
      ep_q    <= ep_d;
      pos_q   <= pos_d;
      rs_q    <= rs_d;
      off_q   <= off_d;
      rep_q   <= rep_d;
      cnt_q   <= '0;
    end
  end

  assign rdy      = rdy_q;
  assign match    = match_q;
  assign startPos = sp_q;
  assign endPos   = ep_q;

endmodule

// File: tb/tb_combination.sv
// tb_combination: random and directed streams against a string-level model.
// Honors COMBINATION_LAST_CHAR_EN the same way as the design.
module tb_combination;

  localparam int PAT_LEN  = 2;
  localparam int MAX_REP  = 4;
  localparam int RST_FULL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy;
  logic [7:0]  char = 8'h00;
  logic        last = 1'b0;
  logic        match;
  logic [31:0] startPos;
  logic [31:0] endPos;

  int checks = 0;
  int errors = 0;

  bit om;
  int os;
  int oe;

  byte unsigned pat [PAT_LEN] = '{8'h61, 8'h62};
  byte unsigned hist [$];
  int cnt = 0;
  int rstart = 0;
  int rend = 0;

  combination #(
    .PAT_LEN  (PAT_LEN),
    .PATTERN  (16'h6162),
    .MAX_REP  (MAX_REP),
    .RST_FULL (RST_FULL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rdy      (rdy),
    .char     (char),
    .last     (last),
    .match    (match),
    .startPos (startPos),
    .endPos   (endPos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    cnt = 0;
    rstart = 0;
    rend = 0;
  endfunction

  // are the chars from index 'from' to the end a prefix of the pattern?
  function automatic bit is_prefix(input int from);
    int len;
    len = hist.size() - from;
    if (len > PAT_LEN) return 1'b0;
    for (int i = 0; i < len; i++)
      if (hist[from+i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // a run is back-to-back pattern occurrences in the text so far
  task automatic model_data(input byte unsigned c, output bit m,
                            output int s, output int e);
    int p;
    bit occ;
    m = 0; s = 0; e = 0;
    hist.push_back(c);
    p = hist.size() - 1;
    occ = (p >= PAT_LEN - 1);
    if (occ)
      for (int i = 0; i < PAT_LEN; i++)
        if (hist[p-PAT_LEN+1+i] != pat[i]) occ = 0;
    if (occ) begin
      if (cnt == 0) rstart = p - PAT_LEN + 1;
      cnt++;
      rend = p;
      if (cnt == MAX_REP) begin
        m = 1; s = rstart; e = p; cnt = 0;
      end
    end else if (cnt > 0 && !is_prefix(rend + 1)) begin
      m = 1; s = rstart; e = rend; cnt = 0;
    end
  endtask

  task automatic model_txn(input byte unsigned c, input bit l,
                           output bit m, output int s, output int e);
    m = 0; s = 0; e = 0;
    if (!l) begin
      model_data(c, m, s, e);
    end else begin
`ifdef COMBINATION_LAST_CHAR_EN
      model_data(c, m, s, e);
`endif
      if (!m && cnt > 0) begin
        m = 1; s = rstart; e = rend;
      end
      model_clear();
    end
  endtask

  // reset pulse of nrst cycles, then one transaction, checked vs model
  task automatic txn(input byte unsigned c, input bit l, input int nrst);
    bit em;
    int es, ee;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", rdy, 0);
    check("rst_match", match, 0);
    for (int i = 1; i < nrst; i++) begin
      @(posedge clk); #1;
    end
    if (nrst >= RST_FULL) model_clear();
    reset = 1'b0;
    char = c;
    last = l;
    model_txn(c, l, em, es, ee);
    @(posedge clk); #1;
    check("rdy_lat0", rdy, 0);
    @(posedge clk); #1;
    check("rdy_lat1", rdy, 1);
    check("match", match, em);
    check("start", startPos, em ? es : 0);
    check("end", endPos, em ? ee : 0);
    om = match;
    os = startPos;
    oe = endPos;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) txn(s[i], 1'b0, 1);
  endtask

  initial begin
    int r;
    byte unsigned c;
    bit l;
    int n;

    // power-up: full reset before the first character
    txn("x", 1'b1, 5);

    send_str("xabab");
    txn("y", 1'b0, 1);
    check("p1_m", om, 1);
    check("p1_s", os, 1);
    check("p1_e", oe, 4);
    txn(8'h00, 1'b1, 1);

    send_str("abababa");
    txn("b", 1'b0, 1);
    check("p2_m", om, 1);
    check("p2_s", os, 0);
    check("p2_e", oe, 7);
    send_str("ab");
    txn(8'h00, 1'b1, 1);
    check("p2l_m", om, 1);
    check("p2l_s", os, 8);
    check("p2l_e", oe, 9);

    send_str("aab");
    txn(8'h00, 1'b1, 1);
    check("p3_m", om, 1);
    check("p3_s", os, 1);
    check("p3_e", oe, 2);

    // outputs hold in DONE until the next reset
    repeat (3) @(posedge clk);
    #1;
    check("hold_rdy", rdy, 1);
    check("hold_match", match, 1);

    send_str("xyz");
    txn(8'h00, 1'b1, 1);
    check("p4_m", om, 0);

    // a 3-cycle reset keeps context, a 5-cycle one clears it
    send_str("a");
    txn("b", 1'b0, 3);
    txn(8'h00, 1'b1, 1);
    check("short_m", om, 1);
    check("short_s", os, 0);
    check("short_e", oe, 1);

    send_str("ab");
    txn("a", 1'b0, 5);
    send_str("b");
    txn(8'h00, 1'b1, 1);
    check("full_m", om, 1);
    check("full_s", os, 0);
    check("full_e", oe, 1);

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 8'h61 : (r < 8) ? 8'h62 : 8'h78;
      l = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 19);
      n = (r == 0) ? 5 : (r == 1) ? 4 : (r == 2) ? 3 : 1;
      txn(c, l, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/combination.md
Name: combination

Overview:
- Streaming regular-expression detector: one character per transaction; detects the fixed pattern PATTERN repeated 1 to MAX_REP times back to back, i.e. (PATTERN){1,MAX_REP}.
- Reports the 0-based start and end character positions of each maximal run.
- Each transaction is a short reset pulse, then a wait for rdy; an end-of-stream transaction (last=1) flushes any pending run.
- Sits behind a byte-source front end that feeds a file or stream one character at a time.

Parameters:
- PAT_LEN, 2, pattern length in characters (1..8).
- PATTERN, {8'h61,8'h62} ("ab"), pattern bytes, first character in the most-significant byte. Pattern must have no proper prefix equal to a suffix.
- MAX_REP, 4, maximum repetitions per reported match (>=1).
- RST_FULL, 4, number of consecutive reset-high cycles that forces a full context clear.

Ports:
- clk input 1: rising-edge clock.
- reset input 1: synchronous, active-high transaction restart. Held >= RST_FULL cycles, it also clears the whole context.
- rdy output 1: transaction complete; outputs valid.
- char input 8: character for this transaction; sampled on the first clock after reset falls.
- last input 1: end-of-stream flag, sampled together with char.
- match output 1: a run was reported in this transaction.
- startPos output 32: index of the first character of the reported run.
- endPos output 32: index of the last character of the reported run.

Behaviour:
- Short reset (high, fewer than RST_FULL cycles):
  - Clears FSM to IDLE; rdy=0, match=0, startPos=0, endPos=0.
  - Context registers are NOT cleared: position counter pos, pattern offset, repetition count, run start.
- Full reset (RST_FULL or more consecutive cycles high): also clears context to pos=0, offset=0, rep=0, run_start=0. Context registers have the same power-up init values.
- FSM: IDLE -> EVAL -> DONE.
  - IDLE: first edge with reset low; latch char and last.
  - EVAL: next edge; update context; set rdy=1 and match.
  - DONE: hold all outputs until reset. Latency is 2 clocks from reset release to rdy=1.
- Data transaction (last=0), with c = latched char:
  - If c == PATTERN[offset]: offset++. On reaching PAT_LEN: offset=0, rep++, and run_start is set to pos-PAT_LEN+1 when rep was 0.
  - If rep reaches MAX_REP: report the run now (match=1, startPos=run_start, endPos=pos) and set rep=0.
  - On mismatch with rep>=1: report with endPos = index of the last character of the last complete repetition. The partial repetition is discarded.
  - Any mismatch then clears offset and rep. If c == PATTERN[0], c begins a new candidate (offset=1).
  - pos increments by 1 after every data transaction (32-bit, wraps).
- Last transaction (last=1):
  - char is ignored and pos is not incremented.
  - If rep>=1, report the pending run.
  - Context then clears to the start-of-stream state.
- match=0 whenever nothing is reported. startPos/endPos read 0 when match=0.
- reset asserted during EVAL/DONE aborts the transaction; context updates from a completed EVAL are kept.

Optional Feature:
- Macro COMBINATION_LAST_CHAR_EN.
- Defined: a last=1 transaction first consumes char as a normal data character (match/increment rules above), then flushes and clears context. At most one match is reported per transaction; if the data step already reported one, the flush report is dropped and the pending run is lost.
- Undefined: char is ignored on last=1.

Test Plan:
- Stream "xababy" then last -> 'y' transaction (index 5) gives match=1, startPos=1, endPos=4; all others match=0.
- "abababab" then "ab" then last, MAX_REP=4 -> index 7 gives match, start 0, end 7; the last transaction gives match, start 8, end 9.
- "aab" then last -> no match on data transactions; the last transaction gives match, start 1, end 2.
- "xyz" then last -> match=0 on all four transactions; rdy=1 in each.
- Timing: reset released before edge k -> rdy=0 at k, rdy=1 after k+1 and held. A new reset pulse drops rdy and match to 0 on the next edge.
- "ab", then reset held 5 cycles, then "ab", then last -> last gives match, start 0, end 1 (context cleared by the full reset).
